// File: rtl/hazard_forward_unit.sv
// Load-use stall, redirect flush and EX operand forwarding for the 5-stage core.
// Keeps a small EX/MEM/WB destination scoreboard; all controls are combinational from it.
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_valid,
    input  logic              ex_redirect,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_ex_vld;
    logic              r_ex_uses_rs1;
    logic              r_ex_uses_rs2;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic [REG_AW-1:0] r_ex_rd;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_mem_vld;
    logic              r_mem_reg_write;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_vld;
    logic              r_wb_reg_write;
    logic [REG_AW-1:0] r_wb_rd;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_load_use;
    logic              w_stall;
    logic              w_mem_wr;
    logic              w_wb_wr;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // Writers of x0 are excluded here so they can never stall or forward.
    assign w_mem_wr = r_mem_vld & r_mem_reg_write & (r_mem_rd != '0);
    assign w_wb_wr  = r_wb_vld & r_wb_reg_write & (r_wb_rd != '0);

    assign w_load_use = r_ex_vld & r_ex_mem_read & r_ex_reg_write & (r_ex_rd != '0) & id_valid &
                        ((id_uses_rs1 & (id_rs1 == r_ex_rd)) | (id_uses_rs2 & (id_rs2 == r_ex_rd)));
    assign w_stall    = reset & w_load_use & ~ex_redirect;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (reset && r_ex_vld) begin
            if (r_ex_uses_rs1 && w_mem_wr && (r_mem_rd == r_ex_rs1)) begin
                w_fwd_a = 2'b10;
            end else if (r_ex_uses_rs1 && w_wb_wr && (r_wb_rd == r_ex_rs1)) begin
                w_fwd_a = 2'b01;
            end
            if (r_ex_uses_rs2 && w_mem_wr && (r_mem_rd == r_ex_rs2)) begin
                w_fwd_b = 2'b10;
            end else if (r_ex_uses_rs2 && w_wb_wr && (r_wb_rd == r_ex_rs2)) begin
                w_fwd_b = 2'b01;
            end
        end
    end

    assign stall_if_id = w_stall;
    assign flush_if_id = reset & ex_redirect;
    assign flush_id_ex = reset & (w_load_use | ex_redirect);
    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign stall_count = reset ? r_stall_cnt : '0;
    assign flush_count = reset ? r_flush_cnt : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_vld    <= 1'b0;
            r_mem_vld   <= 1'b0;
            r_wb_vld    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_wb_vld  <= r_mem_vld;
            r_mem_vld <= r_ex_vld;
            r_ex_vld  <= id_valid & ~w_load_use & ~ex_redirect;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (ex_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    // Payload fields are only meaningful under their slot valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        r_wb_rd         <= r_mem_rd;
        r_wb_reg_write  <= r_mem_reg_write;
        r_mem_rd        <= r_ex_rd;
        r_mem_reg_write <= r_ex_reg_write;
        r_ex_rd         <= id_rd;
        r_ex_rs1        <= id_rs1;
        r_ex_rs2        <= id_rs2;
        r_ex_uses_rs1   <= id_uses_rs1;
        r_ex_uses_rs2   <= id_uses_rs2;
        r_ex_reg_write  <= id_reg_write;
        r_ex_mem_read   <= id_mem_read;
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table, counter saturation sequences,
// then randomized traffic against a stage-list reference model.
module tb_hazard_forward_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic rst_n, vld, u1, u2, rw, mr, redir;
        logic [REG_AW-1:0] rs1, rs2, rd;
    } drive_t;

    typedef struct packed {
        logic stall, fif, fidex;
        logic [1:0] fa, fb;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    typedef struct {
        drive_t d;
        exp_t   e;
    } vec_t;

    typedef struct {
        logic vld, u1, u2, rw, mr;
        int   rd, rs1, rs2;
    } ins_t;

    logic              clk;
    logic              reset;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_valid;
    logic              ex_redirect;
    logic              stall_if_id, flush_if_id, flush_id_ex;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_count, flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    ins_t pipe [3];
    int   m_sc, m_fc;

    hazard_forward_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_valid(id_valid),
        .ex_redirect(ex_redirect),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic drive_t mk(int rd, int rs1, int rs2, logic u1, logic u2, logic rw, logic mr);
        drive_t r;
        r.rst_n = 1'b1; r.vld = 1'b1; r.redir = 1'b0;
        r.u1 = u1; r.u2 = u2; r.rw = rw; r.mr = mr;
        r.rd = REG_AW'(rd); r.rs1 = REG_AW'(rs1); r.rs2 = REG_AW'(rs2);
        return r;
    endfunction

    function automatic drive_t ALU(int rd, int rs1, int rs2);
        return mk(rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic drive_t LOAD(int rd, int rs1);
        return mk(rd, rs1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic drive_t NOP();
        drive_t r;
        r = mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        r.vld = 1'b0;
        return r;
    endfunction

    function automatic drive_t RST(drive_t d);
        drive_t r;
        r = d; r.rst_n = 1'b0;
        return r;
    endfunction

    function automatic drive_t RDR(drive_t d);
        drive_t r;
        r = d; r.redir = 1'b1;
        return r;
    endfunction

    function automatic exp_t E(int st, int fi, int fx, int fa, int fb, int sc, int fc);
        exp_t r;
        r.stall = 1'(st); r.fif = 1'(fi); r.fidex = 1'(fx);
        r.fa = 2'(fa); r.fb = 2'(fb);
        r.sc = CNT_W'(sc); r.fc = CNT_W'(fc);
        return r;
    endfunction

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; forwarding picks the youngest older writer.
    function automatic int fwd_src(int rs, logic uses);
        if (!pipe[0].vld || !uses) return 0;
        for (int s = 1; s <= 2; s++) begin
            if (pipe[s].vld && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == rs) return (s == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic logic model_ld_use(drive_t d);
        return pipe[0].vld && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 && d.vld &&
               ((d.u1 && int'(d.rs1) == pipe[0].rd) || (d.u2 && int'(d.rs2) == pipe[0].rd));
    endfunction

    function automatic exp_t model_out(drive_t d);
        logic lu;
        lu = model_ld_use(d);
        if (!d.rst_n) return E(0, 0, 0, 0, 0, 0, 0);
        return E(lu && !d.redir, d.redir, lu || d.redir,
                 fwd_src(pipe[0].rs1, pipe[0].u1), fwd_src(pipe[0].rs2, pipe[0].u2), m_sc, m_fc);
    endfunction

    task automatic model_step(drive_t d);
        logic lu;
        lu = model_ld_use(d);
        if (!d.rst_n) begin
            for (int s = 0; s < 3; s++) pipe[s].vld = 1'b0;
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (lu && !d.redir && m_sc < MAXC) m_sc = m_sc + 1;
            if (d.redir && m_fc < MAXC) m_fc = m_fc + 1;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].vld = d.vld && !lu && !d.redir;
            pipe[0].u1 = d.u1; pipe[0].u2 = d.u2; pipe[0].rw = d.rw; pipe[0].mr = d.mr;
            pipe[0].rd = int'(d.rd); pipe[0].rs1 = int'(d.rs1); pipe[0].rs2 = int'(d.rs2);
        end
    endtask

    // mode 0: drive only, 1: compare against e, 2: compare against the reference model
    task automatic cycle(input drive_t d, input int mode, input exp_t e, input string nm);
        exp_t act, want;
        reset = d.rst_n; id_valid = d.vld; id_uses_rs1 = d.u1; id_uses_rs2 = d.u2;
        id_reg_write = d.rw; id_mem_read = d.mr; ex_redirect = d.redir;
        id_rs1 = d.rs1; id_rs2 = d.rs2; id_rd = d.rd;
        @(negedge clk);
        act.stall = stall_if_id; act.fif = flush_if_id; act.fidex = flush_id_ex;
        act.fa = fwd_a; act.fb = fwd_b; act.sc = stall_count; act.fc = flush_count;
        want = (mode == 2) ? model_out(d) : e;
        if (mode != 0) begin
            n_cmp++;
            if (act !== want) begin
                n_bad++;
                $display("FAIL %s: got stall=%b fif=%b fidex=%b fa=%b fb=%b sc=%0d fc=%0d, want stall=%b fif=%b fidex=%b fa=%b fb=%b sc=%0d fc=%0d",
                         nm, act.stall, act.fif, act.fidex, act.fa, act.fb, act.sc, act.fc,
                         want.stall, want.fif, want.fidex, want.fa, want.fb, want.sc, want.fc);
            end
        end
        @(posedge clk);
        model_step(d);
        #1;
    endtask

    initial begin
        vec_t   tbl[$];
        drive_t d;
        exp_t   z;

        reset = 1'b0; id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; ex_redirect = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        for (int s = 0; s < 3; s++) pipe[s] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        m_sc = 0;
        m_fc = 0;
        z = E(0, 0, 0, 0, 0, 0, 0);

        tbl.push_back('{RST(RDR(ALU(1, 2, 3))), E(0, 0, 0, 0, 0, 0, 0)});  // reset forces outputs low
        tbl.push_back('{RST(NOP()),             E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{ALU(1, 2, 3),           E(0, 0, 0, 0, 0, 0, 0)});  // EX/MEM forward
        tbl.push_back('{ALU(2, 1, 3),           E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 2, 0, 0, 0)});
        tbl.push_back('{ALU(5, 0, 0),           E(0, 0, 0, 0, 0, 0, 0)});  // MEM/WB forward on rs2
        tbl.push_back('{ALU(6, 9, 10),          E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{ALU(11, 12, 5),         E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 0, 1, 0, 0)});
        tbl.push_back('{LOAD(7, 4),             E(0, 0, 0, 0, 0, 0, 0)});  // load-use
        tbl.push_back('{ALU(8, 7, 7),           E(1, 0, 1, 0, 0, 0, 0)});
        tbl.push_back('{ALU(8, 7, 7),           E(0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 1, 1, 1, 0)});
        tbl.push_back('{ALU(0, 1, 1),           E(0, 0, 0, 0, 0, 1, 0)});  // x0 never forwards or stalls
        tbl.push_back('{ALU(3, 0, 0),           E(0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{LOAD(0, 2),             E(0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{ALU(4, 0, 0),           E(0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 0, 0, 1, 0)});
        tbl.push_back('{LOAD(9, 1),             E(0, 0, 0, 0, 0, 1, 0)});  // redirect beats stall
        tbl.push_back('{RDR(ALU(10, 9, 2)),     E(0, 1, 1, 0, 0, 1, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 0, 0, 1, 1)});
        tbl.push_back('{ALU(13, 1, 1),          E(0, 0, 0, 0, 0, 1, 1)});  // same rd in MEM and WB
        tbl.push_back('{ALU(13, 2, 2),          E(0, 0, 0, 0, 0, 1, 1)});
        tbl.push_back('{ALU(14, 13, 13),        E(0, 0, 0, 0, 0, 1, 1)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 2, 2, 1, 1)});
        tbl.push_back('{LOAD(15, 1),            E(0, 0, 0, 0, 0, 1, 1)});  // reset during a stall
        tbl.push_back('{RST(ALU(16, 15, 1)),    E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{ALU(17, 15, 16),        E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{NOP(),                  E(0, 0, 0, 0, 0, 0, 0)});

        foreach (tbl[i]) cycle(tbl[i].d, 1, tbl[i].e, $sformatf("vec[%0d]", i));

        // flush_count saturation
        cycle(RST(NOP()), 0, z, "rst");
        for (int i = 0; i < MAXC; i++) cycle(RDR(NOP()), 0, z, "redir");
        cycle(RDR(NOP()), 1, E(0, 1, 1, 0, 0, 0, MAXC), "flush_sat_hold");
        cycle(NOP(),      1, E(0, 0, 0, 0, 0, 0, MAXC), "flush_sat_nowrap");

        // stall_count saturation
        cycle(RST(NOP()), 0, z, "rst");
        for (int i = 0; i < MAXC; i++) begin
            cycle(LOAD(1, 0), 0, z, "ld");
            cycle(ALU(2, 1, 1), 0, z, "use");
        end
        cycle(LOAD(1, 0),   0, z, "ld");
        cycle(ALU(2, 1, 1), 1, E(1, 0, 1, 0, 0, MAXC, 0), "stall_sat_hold");
        cycle(LOAD(1, 0),   0, z, "ld");
        cycle(ALU(2, 1, 1), 1, E(1, 0, 1, 0, 0, MAXC, 0), "stall_sat_nowrap");

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            d.rst_n = ($urandom_range(0, 99) >= 3);
            d.vld   = ($urandom_range(0, 99) < 85);
            d.u1    = ($urandom_range(0, 99) < 80);
            d.u2    = ($urandom_range(0, 99) < 60);
            d.rw    = ($urandom_range(0, 99) < 75);
            d.mr    = d.rw && ($urandom_range(0, 99) < 35);
            d.redir = ($urandom_range(0, 99) < 12);
            d.rs1   = REG_AW'($urandom_range(0, 3));
            d.rs2   = REG_AW'($urandom_range(0, 3));
            d.rd    = REG_AW'($urandom_range(0, 3));
            cycle(d, 2, z, $sformatf("rand[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Consumer side of the decoded control bundle: receives per-instruction control (RegWrite, MemRead, branch/jump redirect) plus register indices from the ID stage.
- Tracks in-flight destinations of the EX, MEM and WB stages in an internal shift-register scoreboard.
- Drives the pipeline's stall, flush and operand-forwarding controls.
- Sits beside the ID/EX/MEM/WB pipeline registers in the 5-stage RISC-V core.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs1  in  REG_AW  rs1 index of the instruction in ID.
- id_rs2  in  REG_AW  rs2 index of the instruction in ID.
- id_rd  in  REG_AW  rd index of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- id_reg_write  in  1  RegWrite for the ID instruction.
- id_mem_read  in  1  MemRead for the ID instruction (load).
- id_valid  in  1  the ID slot holds a real instruction.
- ex_redirect  in  1  EX branch taken or jump: PC being redirected this cycle.
- stall_if_id  out  1  hold PC and IF/ID register.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  load a bubble into ID/EX.
- fwd_a  out  2  EX operand A source: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  out  2  EX operand B source, same encoding as fwd_a.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  redirect flushes, saturating.

Behaviour:
- Scoreboard contents:
  - EX slot: valid, rd, rs1, rs2, uses_rs1, uses_rs2, reg_write, mem_read.
  - MEM slot and WB slot: valid, rd, reg_write.
- Slot advance: every clock, WB<=MEM and MEM<=EX.
  - EX<=ID fields when no stall and no redirect.
  - EX<=bubble (valid=0) when load-use stall or ex_redirect.
- Load-use hazard (combinational): EX.valid & EX.mem_read & EX.reg_write & EX.rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
- Outputs, combinational from slot state and inputs:
  - stall_if_id = load_use & !ex_redirect.
  - flush_id_ex = load_use | ex_redirect.
  - flush_if_id = ex_redirect.
- Priority: redirect beats stall. The younger instruction in ID is squashed, so no stall is issued.
- Forwarding for operand A; operand B is identical using rs2/uses_rs2:
  - 10 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.uses_rs1.
  - Else 01 if the same test passes against the WB slot.
  - Else 00.
  - EX.valid=0 forces 00.
  - MEM has priority over WB (newer value).
- Writes to x0 never create a hazard or a forward.
- Register file is write-first. A WB-stage write visible in ID needs no action from this block.
- Latency:
  - Stall/flush are valid in the same cycle the hazard is present in ID/EX.
  - A stalled load proceeds to MEM next cycle. The dependent instruction then enters EX with fwd=01 from the WB slot one cycle later.
- Counters:
  - stall_count increments on each cycle stall_if_id=1.
  - flush_count increments on each cycle ex_redirect=1.
  - Both saturate at all-ones, no wrap.
- Reset (reset==0 at clock edge):
  - All slot valid bits cleared; counters cleared.
  - While reset is low, all outputs are forced to 0: stall, flushes, fwd=00, counts=0.
  - Reset mid-stall cancels the stall on the next edge; no stale forwards appear after release.
- Back-to-back loads into the same rd are resolved correctly because the MEM-over-WB priority picks the youngest.

Test Plan:
- add x1 in ID, then add x2,x1,x3 next cycle -> when the consumer is in EX: fwd_a=10, fwd_b=00, no stall.
- Producer of x5, one unrelated instruction, then consumer using x5 as rs2 -> fwd_b=01.
- lw x7 followed by add x8,x7,x7 -> stall_if_id=1 and flush_id_ex=1 for exactly 1 cycle, stall_count 0->1; next EX cycle fwd_a=fwd_b=01.
- Producer rd=x0 with consumer rs1=x0 -> fwd_a=00. Load to x0 with consumer of x0 -> no stall.
- Load-use condition in the same cycle as ex_redirect=1 -> stall_if_id=0, flush_if_id=1, flush_id_ex=1, flush_count +1, stall_count unchanged.
- Same rd written by the MEM and WB slots -> fwd=10.
- Drive reset=0 during a stall cycle -> next edge: all outputs 0, counters 0. After release with no new producers -> fwd=00 for all consumers.
- Saturation: preload the counter to all-ones via 2^CNT_W-1 redirects -> further redirects leave flush_count at all-ones.
